quadport_scratch_ram: RTL and testbench

Responder end of `quadport_ram_if`: the on-chip scratchpad that serves the feedforward controller's single-word and four-word reads and writes of weights, biases and activations. It also exposes a low-priority host port through which the host preloads weights and inputs and reads back results. A small arbiter/FSM serialises host accesses against accelerator traffic; the accelerator side always wins and never stalls.

---
 rtl/quadport_scratch_ram.sv | 222 ++++++++++++++++++++++
 tb/tb_quadport_scratch_ram.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/quadport_scratch_ram.sv
// quadport_scratch_ram
//
// On-chip scratchpad for the feedforward controller. Serves single-word and
// four-word accelerator reads/writes with one-cycle read latency, and a
// low-priority host port used to preload weights/inputs and read results.
// Accelerator traffic always wins; host accesses only slip into idle cycles.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   qrif_addr_i         accelerator word address (lane k uses addr+k)
//   qrif_ren_i          accelerator read enable
//   qrif_wen_i          accelerator write enable
//   qrif_four_i         1 = four-lane access, 0 = lane a only
//   qrif_din_[a-d]_i    accelerator write data, lanes a..d
//   qrif_dout_[a-d]_o   accelerator read data, lanes a..d (held when ren=0)
//   host_req_i          host request, held until host_ack_o
//   host_wen_i          host 1 = write, 0 = read
//   host_addr_i         host word address
//   host_wdata_i        host write data
//   host_ack_o          one-cycle host completion pulse
//   host_rdata_o        host read data, valid with host_ack_o
//   err_o               sticky out-of-range flag, cleared only by RST

module quadport_scratch_ram #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic [15:0] qrif_addr_i,
    input  logic        qrif_ren_i,
    input  logic        qrif_wen_i,
    input  logic        qrif_four_i,
    input  logic [31:0] qrif_din_a_i,
    input  logic [31:0] qrif_din_b_i,
    input  logic [31:0] qrif_din_c_i,
    input  logic [31:0] qrif_din_d_i,
    output logic [31:0] qrif_dout_a_o,
    output logic [31:0] qrif_dout_b_o,
    output logic [31:0] qrif_dout_c_o,
    output logic [31:0] qrif_dout_d_o,

    input  logic        host_req_i,
    input  logic        host_wen_i,
    input  logic [15:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    output logic        host_ack_o,
    output logic [31:0] host_rdata_o,

    output logic        err_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Range checks are done in 17 bits so addr+k never wraps into low memory.
    localparam logic [16:0] DepthW = 17'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StWait
    } host_state_e;

    // ------------------------------------------------------------------
    // Storage (contents are intentionally not reset)
    // ------------------------------------------------------------------
    logic [31:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Accelerator lane decode
    // ------------------------------------------------------------------
    logic [31:0]   din        [4];
    logic [16:0]   lane_addr  [4];
    logic [AW-1:0] lane_idx   [4];
    logic [31:0]   lane_rdata [4];
    logic [3:0]    lane_act;
    logic [3:0]    lane_ok;
    logic          acc_active;
    logic          acc_oor;

    assign din[0] = qrif_din_a_i;
    assign din[1] = qrif_din_b_i;
    assign din[2] = qrif_din_c_i;
    assign din[3] = qrif_din_d_i;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k]  = {1'b0, qrif_addr_i} + 17'(k);
            lane_act[k]   = (k == 0) || qrif_four_i;
            lane_ok[k]    = lane_addr[k] < DepthW;
            lane_idx[k]   = lane_addr[k][AW-1:0];
            // Inactive or out-of-range lanes read as zero.
            lane_rdata[k] = (lane_act[k] && lane_ok[k]) ? mem_q[lane_idx[k]] : 32'h0;
        end
    end

    assign acc_active = qrif_ren_i || qrif_wen_i;
    assign acc_oor    = acc_active && (|(lane_act & ~lane_ok));

    // ------------------------------------------------------------------
    // Accelerator read data registers
    // ------------------------------------------------------------------
    logic [31:0] dout_q [4];
    logic [31:0] dout_d [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            dout_d[k] = qrif_ren_i ? lane_rdata[k] : dout_q[k];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 4; k++) begin
                dout_q[k] <= 32'h0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                dout_q[k] <= dout_d[k];
            end
        end
    end

    assign qrif_dout_a_o = dout_q[0];
    assign qrif_dout_b_o = dout_q[1];
    assign qrif_dout_c_o = dout_q[2];
    assign qrif_dout_d_o = dout_q[3];

    // ------------------------------------------------------------------
    // Host arbitration FSM
    // ------------------------------------------------------------------
    host_state_e state_q;
    host_state_e state_d;
    logic        host_do;
    logic        host_ok;
    logic [AW-1:0] host_idx;

    assign host_ok  = {1'b0, host_addr_i} < DepthW;
    assign host_idx = host_addr_i[AW-1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // Any accelerator activity stalls the host.
                if (host_req_i && !acc_active) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StWait;
            end
            StWait: begin
                // Holding req must not trigger a second access.
                if (!host_req_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        host_ack_o = (state_q == StAck);
        host_do    = (state_q == StIdle) && host_req_i && !acc_active;
    end

    // ------------------------------------------------------------------
    // Host read data and sticky error flag
    // ------------------------------------------------------------------
    logic [31:0] host_rdata_q;
    logic [31:0] host_rdata_d;
    logic        err_q;
    logic        err_d;

    always_comb begin
        host_rdata_d = host_rdata_q;
        if (host_do) begin
            host_rdata_d = (!host_wen_i && host_ok) ? mem_q[host_idx] : 32'h0;
        end
    end

    assign err_d = err_q || acc_oor || (host_do && !host_ok);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            host_rdata_q <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            host_rdata_q <= host_rdata_d;
            err_q        <= err_d;
        end
    end

    assign host_rdata_o = host_rdata_q;
    assign err_o        = err_q;

    // ------------------------------------------------------------------
    // Memory write ports. Host and accelerator writes are mutually
    // exclusive by construction (host_do requires no accelerator access).
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (qrif_wen_i && lane_act[k] && lane_ok[k]) begin
                mem_q[lane_idx[k]] <= din[k];
            end
        end
        if (host_do && host_wen_i && host_ok) begin
            mem_q[host_idx] <= host_wdata_i;
        end
    end

endmodule

// File: tb/tb_quadport_scratch_ram.sv
module tb_quadport_scratch_ram;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] qrif_addr = 16'h0;
    logic        qrif_ren = 1'b0;
    logic        qrif_wen = 1'b0;
    logic        qrif_four = 1'b0;
    logic [31:0] din_a = 32'h0;
    logic [31:0] din_b = 32'h0;
    logic [31:0] din_c = 32'h0;
    logic [31:0] din_d = 32'h0;
    logic [31:0] dout_a;
    logic [31:0] dout_b;
    logic [31:0] dout_c;
    logic [31:0] dout_d;
    logic        host_req = 1'b0;
    logic        host_wen = 1'b0;
    logic [15:0] host_addr = 16'h0;
    logic [31:0] host_wdata = 32'h0;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    quadport_scratch_ram #(.DEPTH(1024)) u_dut (
        .CLK           (CLK),
        .RST           (RST),
        .qrif_addr_i   (qrif_addr),
        .qrif_ren_i    (qrif_ren),
        .qrif_wen_i    (qrif_wen),
        .qrif_four_i   (qrif_four),
        .qrif_din_a_i  (din_a),
        .qrif_din_b_i  (din_b),
        .qrif_din_c_i  (din_c),
        .qrif_din_d_i  (din_d),
        .qrif_dout_a_o (dout_a),
        .qrif_dout_b_o (dout_b),
        .qrif_dout_c_o (dout_c),
        .qrif_dout_d_o (dout_d),
        .host_req_i    (host_req),
        .host_wen_i    (host_wen),
        .host_addr_i   (host_addr),
        .host_wdata_i  (host_wdata),
        .host_ack_o    (host_ack),
        .host_rdata_o  (host_rdata),
        .err_o         (err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic acc(input logic ren, input logic wen, input logic four,
                       input logic [15:0] addr, input logic [31:0] da, input logic [31:0] db,
                       input logic [31:0] dc, input logic [31:0] dd);
        qrif_ren  = ren;
        qrif_wen  = wen;
        qrif_four = four;
        qrif_addr = addr;
        din_a = da;
        din_b = db;
        din_c = dc;
        din_d = dd;
        tick();
        qrif_ren = 1'b0;
        qrif_wen = 1'b0;
    endtask

    // Full host transaction: req until ack, drop req, let FSM return to idle.
    task automatic host_xact(input logic wen, input logic [15:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output int ack_cyc);
        int waited;
        host_req   = 1'b1;
        host_wen   = wen;
        host_addr  = addr;
        host_wdata = wdata;
        waited = 0;
        tick();
        while (host_ack !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (host_ack !== 1'b1) check_eq("host_timeout", {31'h0, host_ack}, 32'h1);
        rdata   = host_rdata;
        ack_cyc = cyc;
        host_req = 1'b0;
        tick();
        check_eq("host_ack_pulse", {31'h0, host_ack}, 32'h0);
        tick();
    endtask

    logic [31:0] rd;
    int          ack_t [4];
    int          tdummy;

    initial begin
        // Reset values
        #2;
        check_eq("rst_dout_a", dout_a, 32'h0);
        check_eq("rst_dout_d", dout_d, 32'h0);
        check_eq("rst_ack", {31'h0, host_ack}, 32'h0);
        check_eq("rst_rdata", host_rdata, 32'h0);
        check_eq("rst_err", {31'h0, err}, 32'h0);
        tick();
        tick();
        #2;
        RST = 1'b0;
        tick();

        // Host preload, acks 3 cycles apart
        host_xact(1'b1, 16'h0010, 32'h11, rd, ack_t[0]);
        host_xact(1'b1, 16'h0011, 32'h22, rd, ack_t[1]);
        host_xact(1'b1, 16'h0012, 32'h33, rd, ack_t[2]);
        host_xact(1'b1, 16'h0013, 32'h44, rd, ack_t[3]);
        check_eq("host_wr_rdata0", rd, 32'h0);
        for (int i = 1; i < 4; i++) begin
            check_eq("host_spacing", 32'(ack_t[i] - ack_t[i-1]), 32'd3);
        end

        // Four-word read
        acc(1'b1, 1'b0, 1'b1, 16'h0010, 0, 0, 0, 0);
        check_eq("rd4_a", dout_a, 32'h11);
        check_eq("rd4_b", dout_b, 32'h22);
        check_eq("rd4_c", dout_c, 32'h33);
        check_eq("rd4_d", dout_d, 32'h44);
        tick();
        check_eq("hold_c", dout_c, 32'h33);

        // Single-word read and write
        acc(1'b1, 1'b0, 1'b0, 16'h0012, 0, 0, 0, 0);
        check_eq("rd1_a", dout_a, 32'h33);
        check_eq("rd1_b", dout_b, 32'h0);
        check_eq("rd1_d", dout_d, 32'h0);
        acc(1'b0, 1'b1, 1'b0, 16'h0012, 32'hAB, 32'hDEAD, 32'hDEAD, 32'hDEAD);
        acc(1'b1, 1'b0, 1'b1, 16'h0012, 0, 0, 0, 0);
        check_eq("wr1_a", dout_a, 32'hAB);
        check_eq("wr1_b_untouched", dout_b, 32'h44);
        check_eq("err_clean", {31'h0, err}, 32'h0);

        // Priority: host read stalled by 5 accelerator reads
        host_req  = 1'b1;
        host_wen  = 1'b0;
        host_addr = 16'h0010;
        qrif_ren  = 1'b1;
        qrif_four = 1'b1;
        qrif_addr = 16'h0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("prio_ack_low", {31'h0, host_ack}, 32'h0);
            check_eq("prio_dout_c", dout_c, 32'hAB);
        end
        qrif_ren = 1'b0;
        tick();
        check_eq("prio_ack", {31'h0, host_ack}, 32'h1);
        check_eq("prio_rdata", host_rdata, 32'h11);
        host_req = 1'b0;
        tick();
        check_eq("prio_ack_pulse", {31'h0, host_ack}, 32'h0);
        tick();

        // Boundary at DEPTH-2
        host_xact(1'b1, 16'd1022, 32'hA1, rd, tdummy);
        host_xact(1'b1, 16'd1023, 32'hA2, rd, tdummy);
        host_xact(1'b1, 16'd0, 32'h77, rd, tdummy);
        host_xact(1'b1, 16'd1, 32'h78, rd, tdummy);
        check_eq("err_pre_bound", {31'h0, err}, 32'h0);
        acc(1'b1, 1'b0, 1'b1, 16'd1022, 0, 0, 0, 0);
        check_eq("bnd_a", dout_a, 32'hA1);
        check_eq("bnd_b", dout_b, 32'hA2);
        check_eq("bnd_c", dout_c, 32'h0);
        check_eq("bnd_d", dout_d, 32'h0);
        check_eq("bnd_err", {31'h0, err}, 32'h1);
        acc(1'b0, 1'b1, 1'b1, 16'd1022, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
        acc(1'b1, 1'b0, 1'b1, 16'd1022, 0, 0, 0, 0);
        check_eq("bwr_a", dout_a, 32'hB1);
        check_eq("bwr_b", dout_b, 32'hB2);
        check_eq("bwr_c", dout_c, 32'h0);
        acc(1'b1, 1'b0, 1'b0, 16'd0, 0, 0, 0, 0);
        check_eq("nowrap_0", dout_a, 32'h77);
        acc(1'b1, 1'b0, 1'b0, 16'd1, 0, 0, 0, 0);
        check_eq("nowrap_1", dout_a, 32'h78);

        // Read-before-write
        acc(1'b0, 1'b1, 1'b0, 16'h0020, 32'h5, 0, 0, 0);
        acc(1'b1, 1'b1, 1'b1, 16'h0020, 32'h9, 32'hA, 32'hB, 32'hC);
        check_eq("rbw_old", dout_a, 32'h5);
        acc(1'b1, 1'b0, 1'b1, 16'h0020, 0, 0, 0, 0);
        check_eq("rbw_new_a", dout_a, 32'h9);
        check_eq("rbw_new_d", dout_d, 32'hC);

        // Reset in the middle of a host transaction
        host_xact(1'b1, 16'h0030, 32'h66, rd, tdummy);
        host_req  = 1'b1;
        host_wen  = 1'b0;
        host_addr = 16'h0011;
        tick();
        check_eq("pre_rst_ack", {31'h0, host_ack}, 32'h1);
        RST = 1'b1;
        #1;
        check_eq("mid_rst_ack", {31'h0, host_ack}, 32'h0);
        check_eq("mid_rst_dout", dout_a, 32'h0);
        check_eq("mid_rst_err", {31'h0, err}, 32'h0);
        host_req = 1'b0;
        #1;
        RST = 1'b0;
        tick();
        host_xact(1'b0, 16'h0030, 32'h0, rd, tdummy);
        check_eq("post_rst_rd", rd, 32'h66);
        host_xact(1'b0, 16'h0011, 32'h0, rd, tdummy);
        check_eq("post_rst_rd2", rd, 32'h22);

        // Host out-of-range read
        check_eq("err_post_rst", {31'h0, err}, 32'h0);
        host_xact(1'b0, 16'h0400, 32'h0, rd, tdummy);
        check_eq("host_oor_rd", rd, 32'h0);
        check_eq("host_oor_err", {31'h0, err}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
